// File: rtl/pipeline_hazard_sequencer_if.sv
// pipeline_hazard_sequencer_if: pipeline stage info in, stall/flush/forward controls and statistics out
interface pipeline_hazard_sequencer_if;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs, id_use_rt;
  logic        ex_reg_write, mem_reg_write, wb_reg_write;
  logic        ex_mem_to_reg, ex_branch_taken, id_jump, ex_syscall_halt, go;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd, id_use_rs, id_use_rt,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_to_reg, ex_branch_taken,
           id_jump, ex_syscall_halt, go,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, halted, fwd_a, fwd_b,
           cycle_cnt, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd, id_use_rs, id_use_rt,
           ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_to_reg, ex_branch_taken,
           id_jump, ex_syscall_halt, go,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, halted, fwd_a, fwd_b,
           cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: stall/flush/forward control with RUN/DRAIN/HALTED halt sequencing.
// Define HAZARD_FORWARD_EN to enable operand forwarding (only load-use then stalls).
module pipeline_hazard_sequencer (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_sequencer_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [1:0] drain_cnt;
  logic hazard, stall, jmp_flush, pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic [1:0] fwd_a, fwd_b;
  function automatic logic hit(input logic [4:0] r, input logic we, input logic [4:0] rd);
    return we && rd != 5'd0 && rd == r;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
`ifdef HAZARD_FORWARD_EN
  assign hazard = bus.ex_mem_to_reg &&
                  ((bus.id_use_rs && hit(bus.id_rs, bus.ex_reg_write, bus.ex_rd)) ||
                   (bus.id_use_rt && hit(bus.id_rt, bus.ex_reg_write, bus.ex_rd)));
  assign fwd_a = hit(bus.ex_rs, bus.mem_reg_write, bus.mem_rd) ? 2'b10 :
                 hit(bus.ex_rs, bus.wb_reg_write, bus.wb_rd) ? 2'b01 : 2'b00;
  assign fwd_b = hit(bus.ex_rt, bus.mem_reg_write, bus.mem_rd) ? 2'b10 :
                 hit(bus.ex_rt, bus.wb_reg_write, bus.wb_rd) ? 2'b01 : 2'b00;
`else
  // Register file is write-before-read, so a WB producer never needs a stall.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{bus.ex_mem_to_reg, bus.wb_reg_write, bus.wb_rd, bus.ex_rs, bus.ex_rt};
  assign hazard = (bus.id_use_rs && (hit(bus.id_rs, bus.ex_reg_write, bus.ex_rd) ||
                                     hit(bus.id_rs, bus.mem_reg_write, bus.mem_rd))) ||
                  (bus.id_use_rt && (hit(bus.id_rt, bus.ex_reg_write, bus.ex_rd) ||
                                     hit(bus.id_rt, bus.mem_reg_write, bus.mem_rd)));
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif
  always_comb begin
    state_nx = state;
    pc_en = 1'b1;
    if_id_en = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall = 1'b0;
    jmp_flush = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_syscall_halt) begin
          state_nx = DRAIN;
          pc_en = 1'b0;
          if_id_en = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hazard) begin
          stall = 1'b1;
          pc_en = 1'b0;
          if_id_en = 1'b0;
          id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
          jmp_flush = 1'b1;
          if_id_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en = 1'b0;
        if_id_en = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nx = (drain_cnt == 2'd1) ? HALTED : DRAIN;
      end
      HALTED: begin
        pc_en = 1'b0;
        if_id_en = 1'b0;
        state_nx = bus.go ? RUN : HALTED;
      end
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      drain_cnt <= 2'd0;
      bus.cycle_cnt <= 32'd0;
      bus.stall_cnt <= 32'd0;
      bus.flush_cnt <= 32'd0;
    end else begin
      state <= state_nx;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      bus.cycle_cnt <= sat_inc(bus.cycle_cnt, state != HALTED);
      bus.stall_cnt <= sat_inc(bus.stall_cnt, stall);
      bus.flush_cnt <= sat_inc(bus.flush_cnt, state == RUN && (bus.ex_branch_taken || jmp_flush));
    end
  end
  assign bus.pc_en = !rst_n || pc_en;
  assign bus.if_id_en = !rst_n || if_id_en;
  assign bus.if_id_flush = rst_n && if_id_flush;
  assign bus.id_ex_flush = rst_n && id_ex_flush;
  assign bus.fwd_a = rst_n ? fwd_a : 2'b00;
  assign bus.fwd_b = rst_n ? fwd_b : 2'b00;
  assign bus.halted = (state == HALTED);
endmodule
